// File: rtl/sgd_fifo_pkg.sv
// rtl/sgd_fifo_pkg.sv - shared types, count-width helper and parameter legality check for SGD FIFOs
package sgd_fifo_pkg;

  typedef enum logic {
    RD_MODE_STD  = 1'b0,
    RD_MODE_FWFT = 1'b1
  } rd_mode_e;

  localparam int RD_LATENCY_MIN = 1;
  localparam int RD_LATENCY_MAX = 2;

  // Count must represent 0..2**depth_bits inclusive.
  function automatic int count_width(input int depth_bits);
    return depth_bits + 1;
  endfunction

  function automatic bit params_legal(input int depth_bits, input int rd_latency,
                                      input int af_thr, input int ae_thr);
    int cap;
    cap = 1 << depth_bits;
    return (depth_bits > 0) &&
           (rd_latency >= RD_LATENCY_MIN) && (rd_latency <= RD_LATENCY_MAX) &&
           (af_thr >= 0) && (af_thr < cap) &&
           (ae_thr >= 0) && (ae_thr < cap);
  endfunction

endpackage

// File: rtl/distram_sdp.sv
// rtl/distram_sdp.sv - simple dual-port LUTRAM: synchronous write, asynchronous read
module distram_sdp #(
  parameter int WIDTH     = 64,
  parameter int ADDR_BITS = 5
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] waddr_i,
  input  logic [WIDTH-1:0]     wdata_i,
  input  logic [ADDR_BITS-1:0] raddr_i,
  output logic [WIDTH-1:0]     rdata_o
);

  logic [WIDTH-1:0] mem_q [0:(1 << ADDR_BITS)-1];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/distram_fifo_fwft.sv
// rtl/distram_fifo_fwft.sv - distributed-RAM FIFO with exact flags and standard or FWFT read mode
module distram_fifo_fwft
  import sgd_fifo_pkg::*;
#(
  parameter int FIFO_WIDTH                 = 64,
  parameter int FIFO_DEPTH_BITS            = 5,
  parameter int FIFO_ALMOSTFULL_THRESHOLD  = 2**FIFO_DEPTH_BITS - 6,
  parameter int FIFO_ALMOSTEMPTY_THRESHOLD = 2,
  parameter int FWFT                       = 0,
  parameter int RD_LATENCY                 = 2
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic                                     we,
  input  logic [FIFO_WIDTH-1:0]                    din,
  output logic                                     full,
  output logic                                     almostfull,
  input  logic                                     re,
  output logic [FIFO_WIDTH-1:0]                    dout,
  output logic                                     valid,
  output logic                                     empty,
  output logic                                     almostempty,
  output logic [count_width(FIFO_DEPTH_BITS)-1:0]  count,
  output logic                                     overflow,
  output logic                                     underflow
);

  localparam int AW = FIFO_DEPTH_BITS;
  localparam int CW = count_width(FIFO_DEPTH_BITS);
  localparam logic [CW-1:0] DEPTH_C = CW'(1 << FIFO_DEPTH_BITS);
  localparam logic [CW-1:0] AF_C    = CW'(FIFO_ALMOSTFULL_THRESHOLD);
  localparam logic [CW-1:0] AE_C    = CW'(FIFO_ALMOSTEMPTY_THRESHOLD);
  localparam rd_mode_e      MODE    = (FWFT != 0) ? RD_MODE_FWFT : RD_MODE_STD;

  if (!params_legal(FIFO_DEPTH_BITS, RD_LATENCY, FIFO_ALMOSTFULL_THRESHOLD,
                    FIFO_ALMOSTEMPTY_THRESHOLD)) begin : g_bad_params
    $error("distram_fifo_fwft: illegal parameter combination");
  end

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d, mem_count;
  logic [FIFO_WIDTH-1:0] dout_q, dout_d, stage_data_q, stage_data_d;
  logic                  valid_q, valid_d, stage_valid_q, stage_valid_d;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;
  logic [FIFO_WIDTH-1:0] mem_rdata;
  logic                  wr_acc, consume, underrun, mem_has_word, load_head, bypass;

  assign full        = (count_q == DEPTH_C);
  assign empty       = (count_q == '0);
  assign almostfull  = (count_q > AF_C);
  assign almostempty = (count_q <= AE_C);
  assign wr_acc      = we & ~full;
  // In FWFT mode the head word sits in dout_q but is still counted.
  assign mem_count   = count_q - CW'(valid_q);

  distram_sdp #(
    .WIDTH    (FIFO_WIDTH),
    .ADDR_BITS(AW)
  ) u_mem (
    .clk    (clk),
    .we_i   (wr_acc),
    .waddr_i(wr_ptr_q),
    .wdata_i(din),
    .raddr_i(rd_ptr_q),
    .rdata_o(mem_rdata)
  );

  always_comb begin
    consume       = 1'b0;
    underrun      = 1'b0;
    mem_has_word  = 1'b0;
    load_head     = 1'b0;
    bypass        = 1'b0;
    stage_valid_d = 1'b0;
    stage_data_d  = stage_data_q;
    valid_d       = 1'b0;
    dout_d        = dout_q;

    if (MODE == RD_MODE_FWFT) begin
      mem_has_word = (mem_count != '0);
      consume      = re & valid_q;
      underrun     = re & ~valid_q;
      if (~valid_q | consume) begin
        load_head = mem_has_word | wr_acc;
        // Empty memory: the incoming word goes straight to the head register
        // (it is still written to memory, and rd_ptr skips past it).
        bypass    = ~mem_has_word & wr_acc;
      end
      valid_d = load_head | (valid_q & ~consume);
      if (load_head) begin
        dout_d = bypass ? din : mem_rdata;
      end
      rd_ptr_d = rd_ptr_q + AW'(load_head);
    end else begin
      consume  = re & ~empty;
      underrun = re & empty;
      if (RD_LATENCY == 1) begin
        valid_d = consume;
        if (consume) begin
          dout_d = mem_rdata;
        end
      end else begin
        stage_valid_d = consume;
        if (consume) begin
          stage_data_d = mem_rdata;
        end
        valid_d = stage_valid_q;
        if (stage_valid_q) begin
          dout_d = stage_data_q;
        end
      end
      rd_ptr_d = rd_ptr_q + AW'(consume);
    end

    wr_ptr_d    = wr_ptr_q + AW'(wr_acc);
    count_d     = count_q + CW'(wr_acc) - CW'(consume);
    overflow_d  = overflow_q | (we & full);
    underflow_d = underflow_q | underrun;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      dout_q        <= '0;
      valid_q       <= 1'b0;
      stage_data_q  <= '0;
      stage_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      dout_q        <= dout_d;
      valid_q       <= valid_d;
      stage_data_q  <= stage_data_d;
      stage_valid_q <= stage_valid_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
    end
  end

  assign dout      = dout_q;
  assign valid     = valid_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
